// File: rtl/usr_tx_sequencer.sv
// Nibble serializer driving a 4-bit universal shift register (load, then show/shift per bit).
// Optional even-parity slot enabled by defining USR_TX_SEQUENCER_PARITY_EN.
module usr_tx_sequencer (
  input  logic       Clk_In,
  input  logic       Reset_In,
  input  logic       Enable_In,
  input  logic [3:0] Data_In,
  input  logic       Data_Valid_In,
  input  logic       Direction_In,
  output logic       Data_Ready_Out,
  output logic [1:0] USR_Operation_Select_Out,
  output logic [3:0] USR_Parallel_Data_Out,
  output logic       USR_Serial_Fill_Out,
  output logic       Bit_Strobe_Out,
  output logic [1:0] Bit_Index_Out,
  output logic       Frame_Done_Out,
  output logic       Busy_Out
`ifdef USR_TX_SEQUENCER_PARITY_EN
  ,
  output logic       Parity_Out
`endif
);

  localparam int unsigned NIB_W = 4;
  localparam int unsigned CNT_W = 2;

  localparam logic [1:0] OP_HOLD  = 2'd0;
  localparam logic [1:0] OP_SHL   = 2'd1;
  localparam logic [1:0] OP_SHR   = 2'd2;
  localparam logic [1:0] OP_LOAD  = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SHOW,
    S_SHIFT,
`ifdef USR_TX_SEQUENCER_PARITY_EN
    S_PARITY,
`endif
    S_DONE
  } state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [NIB_W-1:0]   nib, nib_nxt;
  logic               dir, dir_nxt;

  // State, bit counter and latched frame parameters
  always_ff @(posedge Clk_In or posedge Reset_In) begin
    if (Reset_In) begin
      state <= S_IDLE;
      cnt   <= '0;
      nib   <= '0;
      dir   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      nib   <= nib_nxt;
      dir   <= dir_nxt;
    end
  end

  // Next state and state-decoded outputs; Enable_In low freezes everything and quiets outputs
  always_comb begin
    state_nxt                = state;
    cnt_nxt                  = cnt;
    nib_nxt                  = nib;
    dir_nxt                  = dir;
    Data_Ready_Out           = 1'b0;
    USR_Operation_Select_Out = OP_HOLD;
    USR_Parallel_Data_Out    = '0;
    USR_Serial_Fill_Out      = 1'b0;
    Bit_Strobe_Out           = 1'b0;
    Bit_Index_Out            = '0;
    Frame_Done_Out           = 1'b0;
    Busy_Out                 = (state != S_IDLE);
`ifdef USR_TX_SEQUENCER_PARITY_EN
    Parity_Out               = 1'b0;
`endif
    if (Enable_In) begin
      case (state)
        S_IDLE: begin
          Data_Ready_Out = ~Reset_In;
          if (Data_Valid_In) begin
            nib_nxt   = Data_In;
            dir_nxt   = Direction_In;
            cnt_nxt   = '0;
            state_nxt = S_LOAD;
          end
        end
        S_LOAD: begin
          USR_Operation_Select_Out = OP_LOAD;
          USR_Parallel_Data_Out    = nib;
          state_nxt                = S_SHOW;
        end
        S_SHOW: begin
          Bit_Strobe_Out = 1'b1;
          Bit_Index_Out  = cnt;
          if (cnt == CNT_W'(3)) begin
`ifdef USR_TX_SEQUENCER_PARITY_EN
            state_nxt = S_PARITY;
`else
            state_nxt = S_DONE;
`endif
          end else begin
            state_nxt = S_SHIFT;
          end
        end
        S_SHIFT: begin
          USR_Operation_Select_Out = dir ? OP_SHL : OP_SHR;
          cnt_nxt                  = cnt + CNT_W'(1);
          state_nxt                = S_SHOW;
        end
`ifdef USR_TX_SEQUENCER_PARITY_EN
        S_PARITY: begin
          Parity_Out = ^nib;
          state_nxt  = S_DONE;
        end
`endif
        S_DONE: begin
          Frame_Done_Out = 1'b1;
          state_nxt      = S_IDLE;
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_usr_tx_sequencer.sv
// Bench for usr_tx_sequencer: frame-position reference model plus a behavioural USR on the falling edge.
module tb_usr_tx_sequencer;

  logic       Clk_In = 1'b0;
  logic       Reset_In = 1'b1;
  logic       Enable_In = 1'b0;
  logic [3:0] Data_In = '0;
  logic       Data_Valid_In = 1'b0;
  logic       Direction_In = 1'b0;
  logic       Data_Ready_Out;
  logic [1:0] USR_Operation_Select_Out;
  logic [3:0] USR_Parallel_Data_Out;
  logic       USR_Serial_Fill_Out;
  logic       Bit_Strobe_Out;
  logic [1:0] Bit_Index_Out;
  logic       Frame_Done_Out;
  logic       Busy_Out;
`ifdef USR_TX_SEQUENCER_PARITY_EN
  logic       Parity_Out;
  localparam int LAST = 9;
`else
  localparam int LAST = 8;
`endif

  usr_tx_sequencer dut (
    .Clk_In                   (Clk_In),
    .Reset_In                 (Reset_In),
    .Enable_In                (Enable_In),
    .Data_In                  (Data_In),
    .Data_Valid_In            (Data_Valid_In),
    .Direction_In             (Direction_In),
    .Data_Ready_Out           (Data_Ready_Out),
    .USR_Operation_Select_Out (USR_Operation_Select_Out),
    .USR_Parallel_Data_Out    (USR_Parallel_Data_Out),
    .USR_Serial_Fill_Out      (USR_Serial_Fill_Out),
    .Bit_Strobe_Out           (Bit_Strobe_Out),
    .Bit_Index_Out            (Bit_Index_Out),
    .Frame_Done_Out           (Frame_Done_Out),
`ifdef USR_TX_SEQUENCER_PARITY_EN
    .Parity_Out               (Parity_Out),
`endif
    .Busy_Out                 (Busy_Out)
  );

  always #5 Clk_In = ~Clk_In;

  // Behavioural 4-bit universal shift register, sampling on the falling edge
  logic [3:0] usr = '0;
  always @(negedge Clk_In) begin
    case (USR_Operation_Select_Out)
      2'd1:    usr <= {usr[2:0], USR_Serial_Fill_Out};
      2'd2:    usr <= {USR_Serial_Fill_Out, usr[3:1]};
      2'd3:    usr <= USR_Parallel_Data_Out;
      default: usr <= usr;
    endcase
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: frame position 0..LAST within an accepted frame (0 = load slot)
  bit         m_busy = 1'b0;
  int         m_pos  = 0;
  logic [3:0] m_nib  = '0;
  bit         m_dir  = 1'b0;

  task automatic check_outputs();
    bit         act;
    logic [1:0] e_op;
    logic [3:0] e_pd;
    bit         e_stb;
    int         idx;
    act   = Enable_In && m_busy && !Reset_In;
    e_op  = 2'd0;
    e_pd  = 4'd0;
    e_stb = act && (m_pos % 2 == 1) && (m_pos <= 7);
    if (act && m_pos == 0) begin
      e_op = 2'd3;
      e_pd = m_nib;
    end else if (act && m_pos >= 2 && m_pos <= 6 && (m_pos % 2 == 0)) begin
      e_op = m_dir ? 2'd1 : 2'd2;
    end
    chk("ready", 8'(Data_Ready_Out), 8'(Enable_In && !m_busy && !Reset_In));
    chk("busy",  8'(Busy_Out), 8'(m_busy));
    chk("op",    8'(USR_Operation_Select_Out), 8'(e_op));
    chk("pdata", 8'(USR_Parallel_Data_Out), 8'(e_pd));
    chk("fill",  8'(USR_Serial_Fill_Out), 8'd0);
    chk("strobe", 8'(Bit_Strobe_Out), 8'(e_stb));
    chk("done",  8'(Frame_Done_Out), 8'(act && m_pos == LAST));
`ifdef USR_TX_SEQUENCER_PARITY_EN
    chk("parity", 8'(Parity_Out), 8'((act && m_pos == 8) ? ^m_nib : 1'b0));
`endif
    if (e_stb) begin
      idx = (m_pos - 1) / 2;
      chk("index", 8'(Bit_Index_Out), 8'(idx));
      chk("serial_bit", 8'(m_dir ? usr[3] : usr[0]), 8'(m_dir ? m_nib[3 - idx] : m_nib[idx]));
    end
  endtask

  // One clock cycle: apply inputs, advance the reference across the rising edge, check
  task automatic cycle(input bit en, input bit v, input logic [3:0] d, input bit dr, input bit r);
    Enable_In     = en;
    Data_Valid_In = v;
    Data_In       = d;
    Direction_In  = dr;
    Reset_In      = r;
    if (r) begin
      m_busy = 1'b0;
      m_pos  = 0;
      m_nib  = '0;
      m_dir  = 1'b0;
      #1;
      chk("rst_now_busy", 8'(Busy_Out), 8'd0);
      chk("rst_now_op", 8'(USR_Operation_Select_Out), 8'd0);
      chk("rst_now_strobe", 8'(Bit_Strobe_Out), 8'd0);
    end
    @(posedge Clk_In);
    if (!r && en) begin
      if (!m_busy) begin
        if (v) begin
          m_busy = 1'b1;
          m_pos  = 0;
          m_nib  = d;
          m_dir  = dr;
        end
      end else if (m_pos == LAST) begin
        m_busy = 1'b0;
      end else begin
        m_pos++;
      end
    end
    #1;
    check_outputs();
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
  endtask

  initial begin
    // Reset state
    cycle(1'b1, 1'b0, 4'h0, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 4'h0, 1'b0, 1'b1);
    idle_cycles(1);

    // 1011 LSB first, then MSB first
    cycle(1'b1, 1'b1, 4'b1011, 1'b0, 1'b0);
    idle_cycles(LAST + 2);
    cycle(1'b1, 1'b1, 4'b1011, 1'b1, 1'b0);
    idle_cycles(LAST + 2);

    // Valid held: 5 then A, data changing mid-frame
    cycle(1'b1, 1'b1, 4'h5, 1'b0, 1'b0);
    for (int i = 0; i < 2 * (LAST + 2); i++) cycle(1'b1, 1'b1, 4'hA, 1'b0, 1'b0);
    idle_cycles(LAST + 2);

    // Enable low for three cycles while at SHOW1
    cycle(1'b1, 1'b1, 4'b0110, 1'b1, 1'b0);
    idle_cycles(3);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 4'hF, 1'b0, 1'b0);
    idle_cycles(LAST + 2);

    // Reset during the shift following SHOW2, then a clean frame
    cycle(1'b1, 1'b1, 4'b1101, 1'b0, 1'b0);
    idle_cycles(6);
    cycle(1'b1, 1'b0, 4'h0, 1'b0, 1'b1);
    cycle(1'b1, 1'b1, 4'b0111, 1'b1, 1'b0);
    idle_cycles(LAST + 2);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      cycle(($urandom_range(0, 7) != 0), ($urandom_range(0, 1) == 1),
            4'($urandom_range(0, 15)), ($urandom_range(0, 1) == 1),
            ($urandom_range(0, 59) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/usr_tx_sequencer.md
USR_TX_SEQUENCER -- requirements
Module: usr_tx_sequencer

Interface
REQ-001 SHALL have port Clk_In  input  1  single clock; all state updates on rising edge (the downstream 4-bit universal shift register samples on the falling edge).
REQ-002 SHALL have port Reset_In  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port Enable_In  input  1  1 = run; 0 = freeze state, quiesce outputs.
REQ-004 SHALL have port Data_In  input  4  nibble to serialize.
REQ-005 SHALL have port Data_Valid_In  input  1  upstream nibble valid.
REQ-006 SHALL have port Direction_In  input  1  0 = shift right, LSB first; 1 = shift left, MSB first.
REQ-007 SHALL have port Data_Ready_Out  output  1  sequencer can accept a nibble.
REQ-008 SHALL have port USR_Operation_Select_Out  output  2  to USR: 0 = hold, 1 = shift left, 2 = shift right, 3 = parallel load.
REQ-009 SHALL have port USR_Parallel_Data_Out  output  4  to USR parallel input.
REQ-010 SHALL have port USR_Serial_Fill_Out  output  1  to both USR serial inputs; constant 0.
REQ-011 SHALL have port Bit_Strobe_Out  output  1  USR serial output (right side if Direction 0, left side if 1) holds a frame bit for this entire cycle.
REQ-012 SHALL have port Bit_Index_Out  output  2  index of the strobed bit within the frame (0..3).
REQ-013 SHALL have port Frame_Done_Out  output  1  one-cycle pulse at end of frame.
REQ-014 SHALL have port Busy_Out  output  1  high in every state except IDLE.

Function
REQ-015 SHALL implement states IDLE, LOAD, SHOW, SHIFT, DONE (plus PARITY, see Configuration), with a 2-bit bit counter.
REQ-016 SHALL set Data_Ready_Out = 1 only in IDLE with Enable_In = 1.
REQ-017 SHALL accept on a rising edge with Data_Valid_In & Data_Ready_Out: latch Data_In and Direction_In, clear counter, go to LOAD.
REQ-018 SHALL, in LOAD, drive op 3 and the latched nibble on USR_Parallel_Data_Out, then go to SHOW.
REQ-019 SHALL, in SHOW, drive op 0, Bit_Strobe_Out = 1, Bit_Index_Out = counter; if counter = 3 go to DONE (or PARITY), else go to SHIFT.
REQ-020 SHALL, in SHIFT, drive op 2 (Direction 0) or op 1 (Direction 1), increment counter, go to SHOW.
REQ-021 SHALL, in DONE, drive op 0 and Frame_Done_Out = 1 for one cycle, then go to IDLE.
REQ-022 SHALL give a fixed frame length of 9 cycles from accept edge to IDLE: LOAD, SHOW0, SHIFT, SHOW1, SHIFT, SHOW2, SHIFT, SHOW3, DONE.
REQ-023 SHALL drive op 0 and USR_Parallel_Data_Out = 0 in all states other than LOAD.
REQ-024 SHALL ignore Data_Valid_In, Data_In and Direction_In while Busy_Out = 1; the latched values are not affected.
REQ-025 SHALL, while Enable_In = 0, hold state and counter and force op 0, Bit_Strobe_Out = 0, Frame_Done_Out = 0, Data_Ready_Out = 0; it resumes in the same state when Enable_In returns to 1.
REQ-026 SHALL accept a new nibble on the edge leaving IDLE, so at most one idle cycle separates back-to-back frames.

Reset
REQ-027 SHALL, on Reset_In = 1 at any time including mid-frame, immediately enter IDLE and clear the counter and latched data/direction.
REQ-028 SHALL drive all outputs to 0 during reset, except that Data_Ready_Out follows Enable_In after Reset_In deasserts.

Configuration
REQ-029 SHALL recognise macro USR_TX_SEQUENCER_PARITY_EN; when defined, add output Parity_Out (1 bit) and state PARITY, inserted between SHOW3 and DONE.
REQ-030 SHALL, in PARITY, drive op 0 and Parity_Out = XOR of the latched nibble (even parity) for one cycle; Parity_Out = 0 in all other states; frame length becomes 10 cycles.
REQ-031 SHALL, without the macro, have neither the Parity_Out port nor the PARITY state.

Verification
REQ-032 Reset then Enable = 1, Data_In = 4'b1011, Direction = 0, Valid pulse -> ops 3,0,2,0,2,0,2,0,0; the bit seen at USR right-side output in the strobe cycles is 1,1,0,1, with indices 0..3; Frame_Done on the 9th cycle.
REQ-033 Data_In = 4'b1011, Direction = 1 -> ops use 1 for shift; the bit seen at USR left-side output is 1,0,1,1 (MSB first).
REQ-034 Valid held high with two nibbles 4'h5 then 4'hA -> second accept on the first IDLE edge after DONE; Data_In changes mid-frame do not alter the first frame's bits.
REQ-035 Enable_In = 0 for 3 cycles during SHOW1 -> op 0, no strobe; frame resumes at SHOW1 and completes with correct bits.
REQ-036 Reset_In pulsed during SHIFT after SHOW2 -> all outputs 0 immediately; the next accepted nibble produces a clean full frame.
REQ-037 With USR_TX_SEQUENCER_PARITY_EN defined, Data_In = 4'b0111 -> Parity_Out = 1 in the cycle after SHOW3; Frame_Done on cycle 10.
